// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the crossbar masters and the arbiter.
// The master side drives requests and the mask; the slave side returns ownership.
interface bus_arbiter_if #(
  parameter int N   = 16,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   request;
  logic [N-1:0]   req_mask;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [15:0]    hold_cnt;

  modport master (
    output request,
    output req_mask,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  hold_cnt
  );

  modport slave (
    input  request,
    input  req_mask,
    output grant,
    output grant_valid,
    output grant_id,
    output hold_cnt
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin crossbar arbiter: one owner per transaction,
// with an idle bubble between owners and a saturating hold counter.
module bus_arbiter #(
  parameter int N   = 16,
  parameter int IDW = $clog2(N)
) (
  input logic          clk,
  input logic          rst_n,
  bus_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t         state;
  logic [IDW-1:0] last_id;
  logic [N-1:0]   gnt;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [15:0]    cnt;

  logic [N-1:0]   elig;
  logic           sel_found;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] idx;

  assign elig = bus.request & bus.req_mask;

  // Find the first eligible master above last_id, wrapping at N.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = last_id + IDW'(k);
      if (!sel_found && elig[idx]) begin
        sel_found = 1'b1;
        sel       = idx;
      end
    end
  end

  // Ownership FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_id <= IDW'(N - 1);
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_id  <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_found) begin
            state   <= OWN;
            gnt     <= {{(N-1){1'b0}}, 1'b1} << sel;
            gnt_vld <= 1'b1;
            gnt_id  <= sel;
            last_id <= sel;
            cnt     <= 16'd1;
          end
        end
        OWN: begin
          if (!bus.request[gnt_id]) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            gnt_id  <= '0;
            cnt     <= '0;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          gnt     <= '0;
          gnt_vld <= 1'b0;
          gnt_id  <= '0;
          cnt     <= '0;
        end
      endcase
    end
  end

  assign bus.grant       = gnt;
  assign bus.grant_valid = gnt_vld;
  assign bus.grant_id    = gnt_id;
  assign bus.hold_cnt    = cnt;

  a_onehot: assert property (@(posedge clk) $onehot0(gnt));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, rotation, mask,
// mid-grant reset and hold counter saturation.
module tb_bus_arbiter;

  localparam int N = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bus_arbiter_if #(.N(N)) bus ();

  bus_arbiter #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] one_hot;
  logic         held_ok;

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    bus.request      = '0;
    bus.req_mask     = 16'hFFFF;

    // reset for 3 cycles
    for (int i = 0; i < 3; i++) step();
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_valid", 32'(bus.grant_valid), 32'h0);
    check("rst_id", 32'(bus.grant_id), 32'h0);
    check("rst_cnt", 32'(bus.hold_cnt), 32'h0);
    rst_n = 1'b1;
    step();
    check("idle_grant", 32'(bus.grant), 32'h0);

    // single request on master 1 for 4 cycles
    bus.request = 16'h0002;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("m1_grant", 32'(bus.grant), 32'h2);
      check("m1_id", 32'(bus.grant_id), 32'h1);
      check("m1_cnt", 32'(bus.hold_cnt), 32'(i));
    end
    check("m1_valid", 32'(bus.grant_valid), 32'h1);
    bus.request = '0;
    step();
    check("m1_rel", 32'(bus.grant), 32'h0);
    check("m1_rel_cnt", 32'(bus.hold_cnt), 32'h0);

    // simultaneous requests from reset
    do_reset();
    step();
    bus.request = 16'h0003;
    step();
    check("sim_m0", 32'(bus.grant), 32'h1);
    step();
    check("sim_m0_cnt", 32'(bus.hold_cnt), 32'h2);
    bus.request = 16'h0002;
    step();
    check("sim_bub1", 32'(bus.grant), 32'h0);
    step();
    check("sim_m1", 32'(bus.grant), 32'h2);
    check("sim_m1_id", 32'(bus.grant_id), 32'h1);
    bus.request = 16'h0001;
    step();
    check("sim_bub2", 32'(bus.grant), 32'h0);
    check("sim_bub2_v", 32'(bus.grant_valid), 32'h0);
    step();
    check("sim_m0b", 32'(bus.grant), 32'h1);
    bus.request = '0;
    step();
    check("sim_rel", 32'(bus.grant), 32'h0);

    // full rotation 0..15,0
    do_reset();
    bus.request = 16'hFFFF;
    for (int k = 0; k <= N; k++) begin
      one_hot = '0;
      one_hot[k % N] = 1'b1;
      step();
      check("rot_grant", 32'(bus.grant), 32'(one_hot));
      check("rot_id", 32'(bus.grant_id), 32'(k % N));
      step();
      check("rot_hold", 32'(bus.grant), 32'(one_hot));
      bus.request = ~one_hot;
      step();
      check("rot_bubble", 32'(bus.grant), 32'h0);
      bus.request = 16'hFFFF;
    end
    bus.request = '0;
    step();

    // mask excludes master 1
    do_reset();
    bus.req_mask = 16'hFFFD;
    bus.request  = 16'h0002;
    for (int i = 0; i < 10; i++) begin
      step();
      check("mask_block", 32'(bus.grant), 32'h0);
    end
    bus.req_mask = 16'hFFFF;
    step();
    check("mask_open", 32'(bus.grant), 32'h2);
    bus.req_mask = 16'hFFFD;
    for (int i = 2; i <= 4; i++) begin
      step();
      check("mask_keep", 32'(bus.grant), 32'h2);
      check("mask_cnt", 32'(bus.hold_cnt), 32'(i));
    end
    bus.request = '0;
    step();
    check("mask_rel", 32'(bus.grant), 32'h0);
    bus.request = 16'h0002;
    step();
    check("mask_noregrant", 32'(bus.grant), 32'h0);
    bus.request  = '0;
    bus.req_mask = 16'hFFFF;
    step();

    // reset while master 5 owns the bus
    do_reset();
    bus.request = 16'h0020;
    step();
    check("m5_grant", 32'(bus.grant), 32'h20);
    for (int i = 0; i < 6; i++) step();
    check("m5_cnt", 32'(bus.hold_cnt), 32'h7);
    rst_n       = 1'b0;
    bus.request = 16'h0021;
    step();
    check("mid_rst_grant", 32'(bus.grant), 32'h0);
    check("mid_rst_cnt", 32'(bus.hold_cnt), 32'h0);
    check("mid_rst_id", 32'(bus.grant_id), 32'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_m0", 32'(bus.grant), 32'h1);
    bus.request = '0;
    step();
    check("post_rst_rel", 32'(bus.grant), 32'h0);

    // hold counter saturation on master 2
    bus.request = 16'h0004;
    held_ok     = 1'b1;
    step();
    check("sat_grant", 32'(bus.grant), 32'h4);
    check("sat_cnt1", 32'(bus.hold_cnt), 32'h1);
    for (int i = 2; i <= 70000; i++) begin
      step();
      if (bus.grant !== 16'h0004) held_ok = 1'b0;
      if (i == 65534)
        check("sat_fffe", 32'(bus.hold_cnt), 32'hFFFE);
      if (i == 65535)
        check("sat_ffff", 32'(bus.hold_cnt), 32'hFFFF);
    end
    check("sat_end", 32'(bus.hold_cnt), 32'hFFFF);
    check("sat_held", 32'(held_ok), 32'h1);
    bus.request = '0;
    step();
    check("sat_rel", 32'(bus.grant), 32'h0);
    check("sat_rel_cnt", 32'(bus.hold_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
